// File: rtl/vga_pkg.sv
// vga_pkg: shared types and default timing for the VGA raster generator.
//   vga_phase_t : phase of one raster axis (VIDEO, FRONT, SYNC, BACK)
//   vga_coord_t : 10-bit pixel/line coordinate
//   VGA_*       : default 640x480 @ 60 Hz timing (25 MHz pixel clock)
//   coord_of()  : narrows an elaboration-time integer to a coordinate
package vga_pkg;

  typedef enum logic [1:0] {
    VIDEO = 2'd0,
    FRONT = 2'd1,
    SYNC  = 2'd2,
    BACK  = 2'd3
  } vga_phase_t;

  typedef logic [9:0] vga_coord_t;

  localparam int unsigned VGA_HVID  = 640;
  localparam int unsigned VGA_HFP   = 16;
  localparam int unsigned VGA_HSYNC = 96;
  localparam int unsigned VGA_HBP   = 48;
  localparam int unsigned VGA_VVID  = 480;
  localparam int unsigned VGA_VFP   = 10;
  localparam int unsigned VGA_VSYNC = 2;
  localparam int unsigned VGA_VBP   = 33;

  // Largest axis length a 10-bit coordinate can address.
  localparam int unsigned VGA_COORD_SPAN = 1024;

  function automatic vga_coord_t coord_of(input int unsigned n);
    return vga_coord_t'(n);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk_25      in  pixel clock
//   rst         in  synchronous active-high reset -> last position, BACK
//   advance     in  step the axis this clock
//   count       out current coordinate, 0..TOT-1 (flop)
//   phase       out phase FSM state (flop), also the debug view of the FSM
//   sync_n      out low while phase == SYNC (flop)
//   active      out high while phase == VIDEO (flop)
//   active_next out value active will take on the next edge (combinational)
//   wrap        out advancing from TOT-1 this clock (combinational)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VID  = VGA_HVID,
  parameter int unsigned FP   = VGA_HFP,
  parameter int unsigned SYNC_W = VGA_HSYNC,
  parameter int unsigned BP   = VGA_HBP
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       advance,
  output vga_coord_t count,
  output vga_phase_t phase,
  output logic       sync_n,
  output logic       active,
  output logic       active_next,
  output logic       wrap
);

  localparam int unsigned TOT = VID + FP + SYNC_W + BP;

  // Last coordinate of each phase; the FSM leaves a phase on that count.
  localparam vga_coord_t LAST_VID  = coord_of(VID - 1);
  localparam vga_coord_t LAST_FP   = coord_of(VID + FP - 1);
  localparam vga_coord_t LAST_SYNC = coord_of(VID + FP + SYNC_W - 1);
  localparam vga_coord_t LAST      = coord_of(TOT - 1);

  vga_coord_t count_next;
  vga_phase_t phase_next;

  always_comb begin
    count_next = count;
    phase_next = phase;
    if (advance) begin
      count_next = (count == LAST) ? '0 : count + vga_coord_t'(1);
      case (phase)
        VIDEO:   if (count == LAST_VID)  phase_next = FRONT;
        FRONT:   if (count == LAST_FP)   phase_next = SYNC;
        SYNC:    if (count == LAST_SYNC) phase_next = BACK;
        BACK:    if (count == LAST)      phase_next = VIDEO;
        default: phase_next = BACK;
      endcase
    end
  end

  assign wrap        = advance && (count == LAST);
  assign active_next = (phase_next == VIDEO);

  // Flags are registered from the next phase so they line up with count.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      count  <= LAST;
      phase  <= BACK;
      sync_n <= 1'b1;
      active <= 1'b0;
    end else begin
      count  <= count_next;
      phase  <= phase_next;
      sync_n <= (phase_next != SYNC);
      active <= (phase_next == VIDEO);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator, one clock per pixel.
//   clk_25         in  25 MHz pixel clock
//   rst            in  synchronous active-high reset
//   horizontal_num out current column, 0..HTOT-1
//   vertical_num   out current line, 0..VTOT-1
//   hsync, vsync   out sync pulses, active low
//   video_on       out inside the visible HVID x VVID window
//   line_start     out high while horizontal_num == 0
//   frame_start    out high while the raster is at (0,0)
//   frame_count    out 8-bit frame counter, only when VGA_FRAME_COUNT_EN is
//                      defined
// Every output is a register; after reset the raster sits at its last
// position so the first released edge lands on (0,0).
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HVID  = VGA_HVID,
  parameter int unsigned HFP   = VGA_HFP,
  parameter int unsigned HSYNC = VGA_HSYNC,
  parameter int unsigned HBP   = VGA_HBP,
  parameter int unsigned VVID  = VGA_VVID,
  parameter int unsigned VFP   = VGA_VFP,
  parameter int unsigned VSYNC = VGA_VSYNC,
  parameter int unsigned VBP   = VGA_VBP
) (
  input  logic       clk_25,
  input  logic       rst,
  output vga_coord_t horizontal_num,
  output vga_coord_t vertical_num,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int unsigned HTOT = HVID + HFP + HSYNC + HBP;
  localparam int unsigned VTOT = VVID + VFP + VSYNC + VBP;

  if (HTOT > VGA_COORD_SPAN || VTOT > VGA_COORD_SPAN) begin : g_bad_total
    $error("vga_timing: HTOT/VTOT exceed the 10-bit coordinate range");
  end
  if (HVID == 0 || HFP == 0 || HSYNC == 0 || HBP == 0 ||
      VVID == 0 || VFP == 0 || VSYNC == 0 || VBP == 0) begin : g_zero_param
    $error("vga_timing: every timing parameter must be non-zero");
  end

  vga_phase_t h_phase, v_phase;
  logic       h_active, v_active, h_active_next, v_active_next;
  logic       h_wrap, v_wrap;

  vga_axis_counter #(.VID(HVID), .FP(HFP), .SYNC_W(HSYNC), .BP(HBP)) u_h_axis (
    .clk_25      (clk_25),
    .rst         (rst),
    .advance     (1'b1),
    .count       (horizontal_num),
    .phase       (h_phase),
    .sync_n      (hsync),
    .active      (h_active),
    .active_next (h_active_next),
    .wrap        (h_wrap)
  );

  // The vertical axis only moves on the clock the line wraps, so its sync
  // edges fall on the same edge horizontal_num returns to 0.
  vga_axis_counter #(.VID(VVID), .FP(VFP), .SYNC_W(VSYNC), .BP(VBP)) u_v_axis (
    .clk_25      (clk_25),
    .rst         (rst),
    .advance     (h_wrap),
    .count       (vertical_num),
    .phase       (v_phase),
    .sync_n      (vsync),
    .active      (v_active),
    .active_next (v_active_next),
    .wrap        (v_wrap)
  );

  // h_wrap means the next position has h == 0; with v_wrap it is (0,0).
  always_ff @(posedge clk_25) begin
    if (rst) begin
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_on    <= h_active_next && v_active_next;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk_25) begin
    if (rst) begin
      frame_count <= 8'd0;
    end else if (h_wrap && v_wrap) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

  // Registered flags must always agree with the FSM states behind them.
  a_video_on: assert property (@(posedge clk_25) disable iff (rst)
    video_on == (h_active && v_active));
  a_hsync: assert property (@(posedge clk_25) disable iff (rst)
    hsync == (h_phase != SYNC));
  a_vsync: assert property (@(posedge clk_25) disable iff (rst)
    vsync == (v_phase != SYNC));

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: bench for vga_timing. One instance at default 640x480
// timing and one at a tiny 8x5 raster; both are compared every clock
// against a model that derives the raster position from a tick count.
module tb_vga_timing;

  // ---------------- clock / reset ----------------
  logic clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  int checks = 0;
  int errors = 0;

  localparam int D_HVID = 640, D_HFP = 16, D_HSY = 96, D_HBP = 48;
  localparam int D_VVID = 480, D_VFP = 10, D_VSY = 2,  D_VBP = 33;
  localparam int S_HVID = 4, S_HFP = 1, S_HSY = 2, S_HBP = 1;
  localparam int S_VVID = 2, S_VFP = 1, S_VSY = 1, S_VBP = 1;
  localparam int S_HTOT = 8, S_VTOT = 5;

  // ---------------- DUTs ----------------
  logic [9:0] h_d, v_d, h_s, v_s;
  logic hs_d, vs_d, vid_d, ls_d, fs_d;
  logic hs_s, vs_s, vid_s, ls_s, fs_s;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc_d, fc_s;
`endif

  vga_timing u_dut_d (
    .clk_25(clk_25), .rst(rst_d),
    .horizontal_num(h_d), .vertical_num(v_d),
    .hsync(hs_d), .vsync(vs_d), .video_on(vid_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_d)
`endif
  );

  vga_timing #(
    .HVID(S_HVID), .HFP(S_HFP), .HSYNC(S_HSY), .HBP(S_HBP),
    .VVID(S_VVID), .VFP(S_VFP), .VSYNC(S_VSY), .VBP(S_VBP)
  ) u_dut_s (
    .clk_25(clk_25), .rst(rst_s),
    .horizontal_num(h_s), .vertical_num(v_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(vid_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_s)
`endif
  );

  // ---------------- reference model ----------------
  // Tick t counts released edges; t = -1 is the reset position, which is
  // the last pixel of a frame, so position follows from t mod frame.
  longint t_d = -1;
  longint t_s = -1;
  always @(posedge clk_25) begin
    t_d <= rst_d ? -64'sd1 : t_d + 1;
    t_s <= rst_s ? -64'sd1 : t_s + 1;
  end

  function automatic logic [24:0] expect_vec(input longint t,
      input int hvid, input int hfp, input int hsy, input int hbp,
      input int vvid, input int vfp, input int vsy, input int vbp);
    longint htot, vtot, f, p;
    int h, v;
    logic hs, vs, vid, ls, fs;
    logic [9:0] hh, vv;
    htot = hvid + hfp + hsy + hbp;
    vtot = vvid + vfp + vsy + vbp;
    f    = htot * vtot;
    p    = ((t % f) + f) % f;
    h    = int'(p % htot);
    v    = int'(p / htot);
    hs   = !(h >= hvid + hfp && h < hvid + hfp + hsy);
    vs   = !(v >= vvid + vfp && v < vvid + vfp + vsy);
    vid  = (h < hvid) && (v < vvid);
    ls   = (h == 0);
    fs   = (h == 0) && (v == 0);
    hh   = h[9:0];
    vv   = v[9:0];
    return {hh, vv, hs, vs, vid, ls, fs};
  endfunction

  function automatic logic [7:0] expect_fc(input longint t, input longint f);
    longint n;
    n = (t < 0) ? 0 : (t / f + 1);
    return 8'(n % 256);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  wire [24:0] vec_d = {h_d, v_d, hs_d, vs_d, vid_d, ls_d, fs_d};
  wire [24:0] vec_s = {h_s, v_s, hs_s, vs_s, vid_s, ls_s, fs_s};

  always @(negedge clk_25) begin
    check("model_default", 64'(vec_d), 64'(expect_vec(t_d, D_HVID, D_HFP,
          D_HSY, D_HBP, D_VVID, D_VFP, D_VSY, D_VBP)));
    check("model_small", 64'(vec_s), 64'(expect_vec(t_s, S_HVID, S_HFP,
          S_HSY, S_HBP, S_VVID, S_VFP, S_VSY, S_VBP)));
`ifdef VGA_FRAME_COUNT_EN
    check("model_fc_default", 64'(fc_d), 64'(expect_fc(t_d, 64'd420000)));
    check("model_fc_small", 64'(fc_s), 64'(expect_fc(t_s, 64'd40)));
`endif
  end

  // ---------------- vector table ----------------
  typedef struct {
    int         k;   // released edges so far
    logic [9:0] h;
    logic [9:0] v;
    logic       hs, vs, vid, ls, fs;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl[NVEC];

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] exp_q[$];
`endif

  task automatic tick();
    @(negedge clk_25);
  endtask

  initial begin
    int idx, low_cnt, first_low, last_low, budget, fs_seen, fs_k0, fs_k1;
    int vs_low, vs_first, vs_last;

    tbl[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{640,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{641,  10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{656,  10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{657,  10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{752,  10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{753,  10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{800,  10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{801,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1440, 10'd639, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1601, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state.
    tick(); tick();
    check("reset_default", 64'(vec_d), {39'd0, 10'd799, 10'd524, 5'b11000});
    check("reset_small", 64'(vec_s), {39'd0, 10'd7, 10'd4, 5'b11000});

    // Default raster: table vectors plus hsync width over line 0.
    rst_d = 1'b0;
    idx = 0; low_cnt = 0; first_low = -1; last_low = -1;
    for (int k = 1; k <= 1700; k++) begin
      tick();
      if (k <= 800 && hs_d == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = k - 1;
        last_low = k - 1;
      end
      if (idx < NVEC && tbl[idx].k == k) begin
        check($sformatf("vec%0d_k%0d", idx, k), 64'(vec_d),
              64'({tbl[idx].h, tbl[idx].v, tbl[idx].hs, tbl[idx].vs,
                   tbl[idx].vid, tbl[idx].ls, tbl[idx].fs}));
        idx++;
      end
    end
    check("hsync_low_clocks", 64'(low_cnt), 64'd96);
    check("hsync_first_low_h", 64'(first_low), 64'd656);
    check("hsync_last_low_h", 64'(last_low), 64'd751);

    // Reset in the middle of visible video.
    budget = 0;
    while (h_d != 10'd300 && budget < 2000) begin
      tick();
      budget++;
    end
    check("reach_h300", 64'(budget < 2000), 64'd1);
    check("mid_video_on", 64'(vid_d), 64'd1);
    rst_d = 1'b1;
    tick();
    check("mid_reset", 64'(vec_d), {39'd0, 10'd799, 10'd524, 5'b11000});
    rst_d = 1'b0;
    tick();
    check("mid_release", 64'(vec_d), {39'd0, 10'd0, 10'd0, 5'b11111});

    // Small raster: frame period and vsync window.
    rst_s = 1'b0;
    fs_seen = 0; fs_k0 = -1; fs_k1 = -1;
    vs_low = 0; vs_first = -1; vs_last = -1;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (fs_s) begin
        if (fs_seen == 0) fs_k0 = k; else if (fs_seen == 1) fs_k1 = k;
        fs_seen++;
      end
      if (k <= 40 && vs_s == 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
        vs_last = k;
      end
    end
    check("small_first_fs", 64'(fs_k0), 64'd1);
    check("small_frame_period", 64'(fs_k1 - fs_k0), 64'(S_HTOT * S_VTOT));
    check("small_vsync_clocks", 64'(vs_low), 64'(S_VSY * S_HTOT));
    check("small_vsync_first", 64'(vs_first), 64'(3 * S_HTOT + 1));
    check("small_vsync_last", 64'(vs_last), 64'(4 * S_HTOT));

    // Random run lengths interrupted by random resets.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(1, 90)) tick();
      rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      rst_s = 1'b0;
    end

`ifdef VGA_FRAME_COUNT_EN
    // Frame counter over 257 frames, including the 255 -> 0 wrap.
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    for (int i = 0; i < 257; i++) exp_q.push_back(8'((i + 1) % 256));
    for (int k = 1; k <= 257 * S_HTOT * S_VTOT; k++) begin
      tick();
      if (fs_s) begin
        if (exp_q.size() == 0) begin
          check("fc_extra_frame", 64'd1, 64'd0);
        end else begin
          check("fc_at_frame_start", 64'(fc_s), 64'(exp_q.pop_front()));
        end
      end
    end
    check("fc_frames_left", 64'(exp_q.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
